// File: rtl/demux_pkg.sv
// Shared constants for the 1x2 round-robin demux: lane select encoding,
// default geometry and the pointer-width helper.
package demux_pkg;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_AF_THRESH = 3;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lane_fifo_fwft.sv
// Per-lane first-word-fall-through FIFO; a word written at edge k is at rdata after edge k.
// Backpressure: push is dropped when full (no pass-through), pop on empty is ignored.
module lane_fifo_fwft
    import demux_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEF_AF_THRESH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full,
    output logic             almost_full
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0);
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage is cleared on reset so the head reads zero before the first push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count       <= count_nxt;
            almost_full <= (count_nxt >= CW'(AF_THRESH));
        end
    end

endmodule

// File: rtl/demux_1x2_8bits_fifo.sv
// Round-robin 1x2 demux into two FWFT lanes, latency 1; ready_in drops while the selected lane is full.
// Optional sticky underflow flag err_underflow when DEMUX_UNDERFLOW_ERR_EN is defined.
module demux_1x2_8bits_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEF_AF_THRESH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic             pop0,
    input  logic             pop1,
    output logic [WIDTH-1:0] data_out0,
    output logic             valid_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid_out1,
    output logic             almost_full0,
    output logic             almost_full1
`ifdef DEMUX_UNDERFLOW_ERR_EN
    ,
    output logic             err_underflow
`endif
);

    logic sel;
    logic push;
    logic full0;
    logic full1;

    // Strict alternation: a full target lane stalls the stream even if the other lane has room.
    assign ready_in = !reset && !((sel == LANE1) ? full1 : full0);
    assign push     = valid_in && ready_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     sel <= LANE0;
        else if (push) sel <= ~sel;
    end

    lane_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_lane0 (
        .clk         (clk),
        .reset       (reset),
        .push        (push && (sel == LANE0)),
        .wdata       (data_in),
        .pop         (pop0),
        .rdata       (data_out0),
        .valid       (valid_out0),
        .full        (full0),
        .almost_full (almost_full0)
    );

    lane_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_lane1 (
        .clk         (clk),
        .reset       (reset),
        .push        (push && (sel == LANE1)),
        .wdata       (data_in),
        .pop         (pop1),
        .rdata       (data_out1),
        .valid       (valid_out1),
        .full        (full1),
        .almost_full (almost_full1)
    );

`ifdef DEMUX_UNDERFLOW_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_underflow <= 1'b0;
        else if ((pop0 && !valid_out0) || (pop1 && !valid_out1))
            err_underflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_demux_1x2_8bits_fifo.sv
// Bench for demux_1x2_8bits_fifo: directed table, corner sequences and random traffic
// against a queue-based lane model.
module tb_demux_1x2_8bits_fifo;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         valid_in = 1'b0;
    logic         ready_in;
    logic         pop0 = 1'b0;
    logic         pop1 = 1'b0;
    logic [W-1:0] data_out0;
    logic         valid_out0;
    logic [W-1:0] data_out1;
    logic         valid_out1;
    logic         almost_full0;
    logic         almost_full1;
`ifdef DEMUX_UNDERFLOW_ERR_EN
    logic         err_underflow;
`endif

    always #5 clk = ~clk;

    demux_1x2_8bits_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .pop0         (pop0),
        .pop1         (pop1),
        .data_out0    (data_out0),
        .valid_out0   (valid_out0),
        .data_out1    (data_out1),
        .valid_out1   (valid_out1),
        .almost_full0 (almost_full0),
        .almost_full1 (almost_full1)
`ifdef DEMUX_UNDERFLOW_ERR_EN
        ,
        .err_underflow(err_underflow)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per lane plus the round-robin pointer.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    bit           msel = 1'b0;
    bit           merr = 1'b0;

    typedef struct {
        bit           vin;
        logic [W-1:0] din;
        bit           p0;
        bit           p1;
        bit           e_rdy;
        bit           e_v0;
        bit           e_v1;
        logic [W-1:0] e_d0;
        logic [W-1:0] e_d1;
        bit           e_af0;
        bit           e_af1;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return msel ? (q1.size() < D) : (q0.size() < D);
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        msel = 1'b0;
        merr = 1'b0;
    endtask

    // One clock: drive at negedge, sample ready before the edge, update the model
    // at the edge, return at the next negedge for output sampling.
    task automatic cyc(input bit vin, input logic [W-1:0] din, input bit p0, input bit p1,
                       output bit rdy);
        bit acc, d0, d1;
        valid_in = vin;
        data_in  = din;
        pop0     = p0;
        pop1     = p1;
        #1;
        rdy = ready_in;
        acc = vin && m_ready();
        d0  = p0 && (q0.size() > 0);
        d1  = p1 && (q1.size() > 0);
        if ((p0 && q0.size() == 0) || (p1 && q1.size() == 0)) merr = 1'b1;
        @(posedge clk);
        if (d0) void'(q0.pop_front());
        if (d1) void'(q1.pop_front());
        if (acc) begin
            if (msel) q1.push_back(din);
            else      q0.push_back(din);
            msel = !msel;
        end
        @(negedge clk);
        valid_in = 1'b0;
        pop0     = 1'b0;
        pop1     = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rdy"}, ready_in, m_ready());
        chk({tag, "_v0"}, valid_out0, q0.size() > 0);
        chk({tag, "_v1"}, valid_out1, q1.size() > 0);
        chk({tag, "_af0"}, almost_full0, q0.size() >= AF);
        chk({tag, "_af1"}, almost_full1, q1.size() >= AF);
        if (q0.size() > 0) chk({tag, "_d0"}, data_out0, q0[0]);
        if (q1.size() > 0) chk({tag, "_d1"}, data_out1, q1[0]);
`ifdef DEMUX_UNDERFLOW_ERR_EN
        chk({tag, "_err"}, err_underflow, merr);
`endif
    endtask

    // Reset asserted mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        chk({tag, "_rst_v0"}, valid_out0, 1'b0);
        chk({tag, "_rst_v1"}, valid_out1, 1'b0);
        chk({tag, "_rst_af0"}, almost_full0, 1'b0);
        chk({tag, "_rst_af1"}, almost_full1, 1'b0);
        chk({tag, "_rst_rdy"}, ready_in, 1'b0);
        chk({tag, "_rst_d0"}, data_out0, 8'h00);
        chk({tag, "_rst_d1"}, data_out1, 8'h00);
`ifdef DEMUX_UNDERFLOW_ERR_EN
        chk({tag, "_rst_err"}, err_underflow, 1'b0);
`endif
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({tag, "_rel_rdy"}, ready_in, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        bit rdy;

        //               vin din   p0 p1  rdy v0 v1 d0     d1     af0 af1
        tbl[0]  = '{1, 8'hA0, 0, 0, 1, 1, 0, 8'hA0, 8'h00, 0, 0};
        tbl[1]  = '{1, 8'hA1, 0, 0, 1, 1, 1, 8'hA0, 8'hA1, 0, 0};
        tbl[2]  = '{1, 8'hA2, 0, 0, 1, 1, 1, 8'hA0, 8'hA1, 0, 0};
        tbl[3]  = '{1, 8'hA3, 0, 0, 1, 1, 1, 8'hA0, 8'hA1, 0, 0};
        tbl[4]  = '{1, 8'hA4, 0, 0, 1, 1, 1, 8'hA0, 8'hA1, 1, 0};
        tbl[5]  = '{1, 8'hA5, 0, 0, 1, 1, 1, 8'hA0, 8'hA1, 1, 1};
        tbl[6]  = '{1, 8'hA6, 0, 0, 1, 1, 1, 8'hA0, 8'hA1, 1, 1};
        tbl[7]  = '{1, 8'hA7, 0, 0, 1, 1, 1, 8'hA0, 8'hA1, 1, 1};
        tbl[8]  = '{1, 8'hA8, 0, 0, 0, 1, 1, 8'hA0, 8'hA1, 1, 1};
        tbl[9]  = '{1, 8'hA8, 1, 0, 0, 1, 1, 8'hA2, 8'hA1, 1, 1};
        tbl[10] = '{1, 8'hA8, 0, 0, 1, 1, 1, 8'hA2, 8'hA1, 1, 1};
        tbl[11] = '{1, 8'hA9, 0, 0, 0, 1, 1, 8'hA2, 8'hA1, 1, 1};
        tbl[12] = '{0, 8'h00, 0, 1, 0, 1, 1, 8'hA2, 8'hA3, 1, 1};
        tbl[13] = '{1, 8'hA9, 0, 0, 1, 1, 1, 8'hA2, 8'hA3, 1, 1};
        tbl[14] = '{0, 8'h00, 1, 0, 0, 1, 1, 8'hA4, 8'hA3, 1, 1};
        tbl[15] = '{0, 8'h00, 1, 0, 1, 1, 1, 8'hA6, 8'hA3, 0, 1};
        tbl[16] = '{0, 8'h00, 1, 0, 1, 1, 1, 8'hA8, 8'hA3, 0, 1};
        tbl[17] = '{0, 8'h00, 1, 0, 1, 0, 1, 8'h00, 8'hA3, 0, 1};

        // Power-on reset state.
        #1;
        chk("por_v0", valid_out0, 1'b0);
        chk("por_v1", valid_out1, 1'b0);
        chk("por_d0", data_out0, 8'h00);
        chk("por_d1", data_out1, 8'h00);
        chk("por_af", {almost_full1, almost_full0}, 2'b00);
        chk("por_rdy", ready_in, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("por_rel_rdy", ready_in, 1'b1);
        @(negedge clk);

        // Directed table: fill, stall on full lane, no pass-through, drain order.
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].vin, tbl[i].din, tbl[i].p0, tbl[i].p1, rdy);
            chk($sformatf("tbl%0d_rdy", i), rdy, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_v0", i), valid_out0, tbl[i].e_v0);
            chk($sformatf("tbl%0d_v1", i), valid_out1, tbl[i].e_v1);
            if (tbl[i].e_v0) chk($sformatf("tbl%0d_d0", i), data_out0, tbl[i].e_d0);
            if (tbl[i].e_v1) chk($sformatf("tbl%0d_d1", i), data_out1, tbl[i].e_d1);
            chk($sformatf("tbl%0d_af0", i), almost_full0, tbl[i].e_af0);
            chk($sformatf("tbl%0d_af1", i), almost_full1, tbl[i].e_af1);
        end
        do_reset("t1");

        // Lane0 full, lane1 empty, sel on lane0: no skip to lane1.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 8'(8'h20 + 2 * k), 1'b0, k > 0, rdy);
            check_model("fill_l0");
            cyc(1'b1, 8'(8'h21 + 2 * k), 1'b0, 1'b0, rdy);
            check_model("fill_l1");
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, rdy);
        check_model("empty_l1");
        cyc(1'b1, 8'hEE, 1'b0, 1'b1, rdy);
        chk("noskip_rdy", rdy, 1'b0);
        chk("noskip_v1", valid_out1, 1'b0);
        chk("noskip_v0", valid_out0, 1'b1);
        chk("noskip_af0", almost_full0, 1'b1);
        chk("noskip_d0", data_out0, 8'h20);
        check_model("noskip");
`ifdef DEMUX_UNDERFLOW_ERR_EN
        chk("uflow_set", err_underflow, 1'b1);
`endif
        do_reset("t2");

        // Same-edge push/pop on a lane holding words, across pointer wrap.
        cyc(1'b1, 8'h30, 1'b0, 1'b0, rdy);
        cyc(1'b1, 8'h31, 1'b0, 1'b0, rdy);
        cyc(1'b1, 8'h32, 1'b0, 1'b0, rdy);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 8'(8'h40 + k), !msel, msel, rdy);
            chk("pp_rdy", rdy, 1'b1);
            chk("pp_v0", valid_out0, 1'b1);
            chk("pp_af0", almost_full0, 1'b0);
            check_model("pp");
        end

        // Reset mid-stream with five words stored.
        do_reset("t3");
        for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h50 + k), 1'b0, 1'b0, rdy);
        check_model("pre_rst");
        do_reset("t4");
        cyc(1'b1, 8'h5A, 1'b0, 1'b0, rdy);
        chk("post_rst_v0", valid_out0, 1'b1);
        chk("post_rst_d0", data_out0, 8'h5A);
        chk("post_rst_v1", valid_out1, 1'b0);

`ifdef DEMUX_UNDERFLOW_ERR_EN
        cyc(1'b0, 8'h00, 1'b0, 1'b1, rdy);
        chk("uflow_pop1", err_underflow, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, rdy);
        chk("uflow_sticky", err_underflow, 1'b1);
        do_reset("t5");
`endif

        // Random traffic against the queue model.
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0, rdy);
            check_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
